// File: rtl/boot_loader_mux.sv
// boot_loader_mux
// Serial boot loader sitting in front of the unified memory data port.
// Bytes arriving on rx_valid/rx_byte are packed little-endian into DATA_W-bit
// words and written from BASE_ADDR upwards while the core is held in reset.
// An idle gap of TIMEOUT cycles ends the load (a partial word is flushed with
// zero upper lanes); the port is then handed to the core through registered
// core_rst/load_done. skip boots without loading, reload returns to loading.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_valid, rx_byte        received byte strobe and data
//   skip, reload             boot-without-load / return-to-load pulses
//   core_addr/wdata/we       core data-port request (only used in DONE)
//   mem_addr/wdata/we        memory data port
//   core_rst, load_done      registered handover to the core
//   word_count               words written during this load
//   overflow                 sticky: bytes arrived with capacity exhausted
module boot_loader_mux #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                MAX_WORDS = 16384,
    parameter int                TIMEOUT   = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_valid,
    input  logic [7:0]                       rx_byte,
    input  logic                             skip,
    input  logic                             reload,
    input  logic [ADDR_W-1:0]                core_addr,
    input  logic [DATA_W-1:0]                core_wdata,
    input  logic                             core_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    output logic                             mem_we,
    output logic                             core_rst,
    output logic                             load_done,
    output logic [$clog2(MAX_WORDS+1)-1:0]   word_count,
    output logic                             overflow
);

    localparam int BPW = DATA_W / 8;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CW  = $clog2(MAX_WORDS + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IW-1:0]       idx_r;
    logic [TW-1:0]       idle_r;
    logic [DATA_W-1:0]   word_r;
    logic [ADDR_W-1:0]   addr_ptr_r;
    logic [CW-1:0]       word_count_r;
    logic                overflow_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                core_rst_r;
    logic                load_done_r;

    logic                full_s;
    logic                last_lane_s;
    logic                byte_in_s;
    logic                accept_s;
    logic                drop_s;
    logic                timeout_s;
    logic                flush_s;
    logic                enter_done_s;
    logic                do_reload_s;
    logic [DATA_W-1:0]   asm_s;

    // Control decode: which byte/timeout/reload events act this cycle.
    always_comb begin
        full_s      = (word_count_r == CW'(MAX_WORDS));
        last_lane_s = (idx_r == IW'(BPW - 1));
        // In WAIT a simultaneous skip wins and the byte is dropped.
        byte_in_s   = rx_valid && ((state_r == ST_LOAD) ||
                                   ((state_r == ST_WAIT) && !skip));
        accept_s    = byte_in_s && !full_s;
        drop_s      = byte_in_s && full_s;
        // Fires on the edge where the idle count would reach TIMEOUT; a byte
        // in the same cycle takes priority.
        timeout_s   = (state_r == ST_LOAD) && !rx_valid &&
                      (idle_r == TW'(TIMEOUT - 1));
        flush_s     = timeout_s && (idx_r != {IW{1'b0}});
        do_reload_s = (state_r == ST_DONE) && reload;
        enter_done_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
    end

    // Byte lane insertion: current word with rx_byte placed at lane idx.
    always_comb begin
        asm_s = word_r;
        for (int l = 0; l < BPW; l++) begin
            if (idx_r == IW'(l)) begin
                asm_s[l*8 +: 8] = rx_byte;
            end else begin
                asm_s[l*8 +: 8] = word_r[l*8 +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (skip) begin
                    state_nxt_s = ST_DONE;
                end else if (rx_valid) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_LOAD: begin
                if (timeout_s) begin
                    state_nxt_s = flush_s ? ST_FLUSH : ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_FLUSH: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (reload) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_WAIT;
        endcase
    end

    // Loader datapath: word assembly, write issue, counters and handover flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r        <= {IW{1'b0}};
            idle_r       <= {TW{1'b0}};
            word_r       <= {DATA_W{1'b0}};
            addr_ptr_r   <= BASE_ADDR;
            word_count_r <= {CW{1'b0}};
            overflow_r   <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= BASE_ADDR;
            mem_wdata_r  <= {DATA_W{1'b0}};
            core_rst_r   <= 1'b1;
            load_done_r  <= 1'b0;
        end else begin
            mem_we_r <= 1'b0;

            if ((state_r == ST_LOAD) && !rx_valid) begin
                idle_r <= idle_r + TW'(1);
            end else begin
                idle_r <= {TW{1'b0}};
            end

            if (accept_s) begin
                if (last_lane_s) begin
                    // Word complete: write lands in the following cycle.
                    mem_we_r     <= 1'b1;
                    mem_addr_r   <= addr_ptr_r;
                    mem_wdata_r  <= asm_s;
                    addr_ptr_r   <= addr_ptr_r + ADDR_W'(BPW);
                    word_count_r <= word_count_r + CW'(1);
                    idx_r        <= {IW{1'b0}};
                    word_r       <= {DATA_W{1'b0}};
                end else begin
                    word_r <= asm_s;
                    idx_r  <= idx_r + IW'(1);
                end
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (flush_s) begin
                // Write registered here so it is driven during FLUSH.
                if (full_s) begin
                    overflow_r <= 1'b1;
                end else begin
                    mem_we_r     <= 1'b1;
                    mem_addr_r   <= addr_ptr_r;
                    mem_wdata_r  <= word_r;
                    addr_ptr_r   <= addr_ptr_r + ADDR_W'(BPW);
                    word_count_r <= word_count_r + CW'(1);
                end
                idx_r  <= {IW{1'b0}};
                word_r <= {DATA_W{1'b0}};
            end else if (do_reload_s) begin
                idx_r        <= {IW{1'b0}};
                word_r       <= {DATA_W{1'b0}};
                addr_ptr_r   <= BASE_ADDR;
                word_count_r <= {CW{1'b0}};
                overflow_r   <= 1'b0;
            end else begin
                idx_r <= idx_r;
            end

            if (enter_done_s) begin
                core_rst_r  <= 1'b0;
                load_done_r <= 1'b1;
            end else if (do_reload_s) begin
                core_rst_r  <= 1'b1;
                load_done_r <= 1'b0;
            end else begin
                core_rst_r  <= core_rst_r;
                load_done_r <= load_done_r;
            end
        end
    end

    // Memory port mux: core owns the port only in DONE.
    always_comb begin
        if (state_r == ST_DONE) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_we;
        end else begin
            mem_addr  = mem_addr_r;
            mem_wdata = mem_wdata_r;
            mem_we    = mem_we_r;
        end
    end

    assign core_rst   = core_rst_r;
    assign load_done  = load_done_r;
    assign word_count = word_count_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/boot_loader_mux.md
Name: boot_loader_mux

Overview:
- Parametrised successor to the core-top UART load path: assembles a serial byte stream into DATA_W-bit words and writes them to the unified memory's data port.
- Holds the core in reset while loading, then hands the port to the core through a registered handover.
- Adds what the fixed 32-bit path lacks: configurable word width, base address, idle-timeout end-of-load with partial-word flush, capacity overflow detection, skip, and re-load without a board reset.

Parameters:
- DATA_W, 32, memory word width in bits; multiple of 8.
- ADDR_W, 32, memory address width.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 16384, load capacity in words.
- TIMEOUT, 1024, idle clk cycles with no byte that end a load.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous reset, active-high.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte, little-endian lane order.
- skip  in  1  pulse: boot without loading.
- reload  in  1  pulse: return to loading.
- core_addr  in  ADDR_W  core data-port address.
- core_wdata  in  DATA_W  core write data.
- core_we  in  1  core write enable, active-high.
- mem_addr  out  ADDR_W  memory port address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable, active-high.
- core_rst  out  1  reset to core pipeline, active-high.
- load_done  out  1  high in DONE.
- word_count  out  $clog2(MAX_WORDS+1)  words written this load.
- overflow  out  1  sticky: bytes arrived after capacity was reached.

Behaviour:
- BPW = DATA_W/8.
- Reset (async): state WAIT; core_rst=1; load_done=0; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; word_count=0; overflow=0; byte lane index 0; idle counter 0. A partial word in progress is discarded.
- States:
  - WAIT: core held in reset, no writes. rx_valid -> LOAD, byte stored in lane 0. skip -> DONE. If skip and rx_valid arrive together, skip wins and the byte is dropped.
  - LOAD:
    - Each rx_valid writes rx_byte to lane idx and increments idx.
    - On the byte completing lane BPW-1: the next cycle drives mem_we=1 for exactly one cycle, mem_addr = BASE_ADDR + word_count*BPW (mod 2^ADDR_W), mem_wdata = assembled word. word_count increments on that same edge and idx returns to 0.
    - Bytes back-to-back every cycle are supported with no loss.
    - If word_count==MAX_WORDS, a received byte is discarded and overflow is set. No write is issued.
    - The idle counter clears on rx_valid and otherwise increments. rx_valid has priority over timeout in the same cycle.
    - When the idle counter reaches TIMEOUT: if idx!=0 -> FLUSH, else -> DONE.
  - FLUSH: one cycle of mem_we=1 with the partial word, unfilled upper lanes zero, at the next address. word_count increments. Next state DONE. If capacity was full, no write occurs and overflow is set.
  - DONE: core_rst=0 and load_done=1, both registered (first low/high on the cycle DONE is entered). mem_addr, mem_wdata and mem_we pass combinationally from core_addr, core_wdata and core_we. rx_valid is ignored. reload -> WAIT.
- Transition into WAIT via reload: clears word_count, overflow, idx and the idle counter; core_rst=1 from the next cycle.
- Outside DONE, the core_* inputs are ignored entirely, and mem_* come from loader registers. mem_we is low except on write cycles.
- skip/reload in states where they are not listed: ignored.

Test Plan:
- DATA_W=32, BASE_ADDR=0: rx bytes 0x13,0x05,0x10,0x00 on consecutive cycles -> mem_we=1 exactly one cycle after the 4th byte, mem_addr=0x0, mem_wdata=0x00100513, word_count=1.
- 9 bytes (last 0xAB), then silence, TIMEOUT=16:
  - writes at 0x0 and 0x4;
  - 16 idle cycles later, FLUSH writes 0x000000AB at 0x8;
  - then DONE, word_count=3, core_rst falls and load_done rises on the same edge.
- MAX_WORDS=2, 12 bytes -> exactly two writes (0x0, 0x4), overflow=1, word_count=2 after timeout.
- skip in WAIT -> DONE next cycle with no mem_we. Then core_addr=0x1234, core_we=1, core_wdata=0xDEADBEEF -> same values appear on mem_* in the same cycle.
- rst pulsed after 2 bytes of a word -> all outputs at reset values immediately. The next 4 bytes write to BASE_ADDR with lanes starting at 0.
- reload in DONE -> WAIT next cycle: core_rst=1, word_count=0, core_we=1 no longer reaches mem_we. A fresh load then starts at BASE_ADDR.
